// File: rtl/ram_copy_dma.sv
// ram_copy_dma: block word-copy engine acting as initiator on the CPU data RAM port.
// Each word costs one read cycle followed by one write cycle. done pulses when
// the block has been copied.
module ram_copy_dma #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_addr,
  input  logic [WIDTH-1:0] dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] src_ptr;
  logic [WIDTH-1:0] dst_ptr;
  logic [WIDTH-1:0] buffer;
  logic [LEN_W-1:0] remaining;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every flop
      // samples the pre-edge values, independent of process evaluation order.
      state <= state_next;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so it is never queued.
  always_comb begin
    // NOTE: default first, so that every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (length != '0) ? READ : DONE;
      READ:    state_next = WRITE;
      WRITE:   state_next = (remaining != LEN_W'(1)) ? READ : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture the request, then advance the pointers and count words down.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the data registers are cleared as well as the state. After a reset,
      // nothing left over from an aborted copy can reach the bus.
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      buffer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
          end
        end
        READ: begin
          buffer  <= mem_rdata;
          src_ptr <= src_ptr + WIDTH'(1);
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + WIDTH'(1);
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode. Uses registered state and pointers only; start has no path to any output.
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    mem_address = '0;
    mem_wdata   = '0;
    mem_enw     = 1'b0;
    case (state)
      READ: begin
        mem_address = src_ptr;
      end
      WRITE: begin
        mem_address = dst_ptr;
        mem_wdata   = buffer;
        mem_enw     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_copy_dma.sv
// tb_ram_copy_dma: scoreboard bench for ram_copy_dma with a behavioural RAM
// and a word-by-word reference copy model.
module tb_ram_copy_dma;

  localparam int WIDTH = 32;
  localparam int LEN_W = 12;
  localparam int MEM_WORDS = 1024;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int cyc;
    int busy_len;
    int writes;
  } done_t;

  logic             clk;
  logic             nrst;
  logic             start;
  logic [WIDTH-1:0] src_addr;
  logic [WIDTH-1:0] dst_addr;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_enw;
  logic [WIDTH-1:0] mem_rdata;

  logic [31:0] ram     [MEM_WORDS];
  logic [31:0] exp_mem [MEM_WORDS];
  logic        pk_en;
  logic [9:0]  pk_addr;
  logic [31:0] pk_data;

  logic [31:0] rq [$];
  wr_t         wq [$];
  done_t       dq [$];

  int cyc;
  int vectors;
  int miscompares;

  ram_copy_dma #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_enw     (mem_enw),
    .mem_rdata   (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, used to time done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with a synchronous write and a combinational read. It aliases on the low 10 address bits.
  assign mem_rdata = ram[mem_address[9:0]];
  always @(posedge clk) begin
    if (mem_enw)    ram[mem_address[9:0]] <= mem_wdata;
    else if (pk_en) ram[pk_addr]          <= pk_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected DUT activity, expected none (t=%0t)", name, $time);
  endtask

  // Write a word into both the RAM and the expected image. This takes one clock cycle.
  task automatic poke(input int a, input logic [31:0] v);
    pk_en   = 1'b1;
    pk_addr = a[9:0];
    pk_data = v;
    exp_mem[a[9:0]] = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Reference model. Word i is read from s+i and then written to d+i, in ascending order.
  // The model applies each copy to the expected image and queues the bus activity it predicts.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int n0, input int max_words, input bit with_done);
    for (int i = 0; i < n && i < max_words; i++) begin
      logic [31:0] ra;
      logic [31:0] wa;
      logic [31:0] data;
      wr_t         w;
      ra = s + 32'(i);
      wa = d + 32'(i);
      data = exp_mem[ra[9:0]];
      rq.push_back(ra);
      w.addr = wa;
      w.data = data;
      wq.push_back(w);
      exp_mem[wa[9:0]] = data;
    end
    if (with_done) begin
      done_t e;
      e.cyc      = n0 + 2 * n;
      e.busy_len = 2 * n + 1;
      e.writes   = n;
      dq.push_back(e);
    end
  endtask

  // Issue a single start pulse. The start edge E0 is the next posedge, after which cyc == n0.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = LEN_W'(n);
    start    = 1'b1;
    model_copy(s, d, n, cyc + 1, n, 1'b1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((dq.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (dq.size() != 0 || busy) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: copy still pending after %0d cycles, expected completion", budget);
      dq.delete();
      rq.delete();
      wq.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++)
      if (ram[i] !== exp_mem[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  // Monitor: checks every cycle of bus activity against the queued expectations.
  initial begin
    int run;
    int wr;
    run = 0;
    wr  = 0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        check("idle_bus", {mem_address, mem_wdata}, 64'd0);
        check("idle_flags", {62'd0, done, mem_enw}, 64'd0);
        run = 0;
        wr  = 0;
      end else begin
        run++;
        if (mem_enw) begin
          wr++;
          if (wq.size() == 0) fail_evt("write");
          else begin
            wr_t w;
            w = wq.pop_front();
            check("write_addr_data", {mem_address, mem_wdata}, {w.addr, w.data});
          end
        end else if (!done) begin
          if (rq.size() == 0) fail_evt("read");
          else check("read_addr", 64'(mem_address), 64'(rq.pop_front()));
        end
        if (done) begin
          check("done_bus", {mem_address, mem_wdata}, 64'd0);
          if (dq.size() == 0) fail_evt("done");
          else begin
            done_t e;
            e = dq.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            check("busy_len", 64'(run), 64'(e.busy_len));
            check("write_count", 64'(wr), 64'(e.writes));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] v0;
    logic [31:0] v1;
    int          n;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    nrst        = 1'b0;
    start       = 1'b0;
    src_addr    = '0;
    dst_addr    = '0;
    length      = '0;
    pk_en       = 1'b0;
    pk_addr     = '0;
    pk_data     = '0;

    // Fill the RAM while the DUT is held in reset; the monitor checks the reset outputs.
    for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Basic copy.
    for (int i = 0; i < 4; i++) poke(16 + i, 32'hA0 + 32'(i));
    issue(32'd16, 32'd64, 4);
    wait_done(30);
    for (int i = 0; i < 4; i++) check("basic_word", 64'(ram[64 + i]), 64'(32'hA0 + 32'(i)));
    check_mem("basic_mem");

    // Zero length.
    issue(32'd500, 32'd600, 0);
    wait_done(10);
    check_mem("zero_mem");

    // Overlapping regions with dst > src: word 0 propagates forward.
    for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
    issue(32'd0, 32'd1, 3);
    wait_done(20);
    for (int i = 0; i < 4; i++) check("overlap_word", 64'(ram[i]), 64'd1);

    // Start pulses during READ (cycle 1), WRITE (cycle 2) and DONE (cycle 17) are ignored.
    @(negedge clk);
    src_addr = 32'd300;
    dst_addr = 32'd400;
    length   = LEN_W'(8);
    start    = 1'b1;
    model_copy(32'd300, 32'd400, 8, cyc + 1, 8, 1'b1);
    @(negedge clk);
    src_addr = 32'd100;
    dst_addr = 32'd200;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(30);
    check_mem("busy_start_mem");

    // Reset after the second write of a length-6 copy.
    @(negedge clk);
    src_addr = 32'd700;
    dst_addr = 32'd800;
    length   = LEN_W'(6);
    start    = 1'b1;
    model_copy(32'd700, 32'd800, 6, cyc + 1, 2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check("reset_outputs", {30'd0, busy, done, mem_address}, 64'd0);
    check("reset_outputs2", {mem_wdata, 31'd0, mem_enw}, 64'd0);
    check("reset_pending", 64'(rq.size() + wq.size()), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_mem("reset_mem");
    issue(32'd900, 32'd950, 3);
    wait_done(20);
    check_mem("after_reset_mem");

    // Pointer wrap-around from all-ones to zero.
    v0 = exp_mem[10'h3FF];
    v1 = exp_mem[0];
    issue(32'hFFFF_FFFF, 32'h0000_0100, 2);
    wait_done(20);
    check("wrap_word0", 64'(ram[10'h100]), 64'(v0));
    check("wrap_word1", 64'(ram[10'h101]), 64'(v1));

    // Back-to-back: start held high is accepted again in the first IDLE cycle after DONE.
    n = $urandom_range(1, 6);
    s = 32'(400 + $urandom_range(0, 50));
    d = 32'(600 + $urandom_range(0, 50));
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = LEN_W'(n);
    start    = 1'b1;
    model_copy(s, d, n, cyc + 1, n, 1'b1);
    model_copy(s, d, n, cyc + 1 + 2 * n + 2, n, 1'b1);
    repeat (2 * n + 3) @(negedge clk);
    start = 1'b0;
    wait_done(60);
    check_mem("b2b_mem");

    // Randomised copies: full 32-bit addresses, including some small overlapping offsets.
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 20);
      s = $urandom;
      d = (t % 2 == 0) ? s + 32'($urandom_range(0, 4)) : $urandom;
      issue(s, d, n);
      wait_done(2 * n + 20);
    end
    check_mem("random_mem");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
